// File: rtl/ethernet_timebase_if.sv
// Ethernet timebase signal bundle: speed handshake, PHY reset request, tick,
// reference clock and PHY status. slave = timebase side, master = consumer side.
interface ethernet_timebase_if;
    logic speed_i;
    logic phy_reset_req_i;
    logic speed_o;
    logic speed_ack_o;
    logic tick_o;
    logic refclk_o;
    logic phy_rst_n_o;
    logic phy_ready_o;

    modport slave (
        input  speed_i,
        input  phy_reset_req_i,
        output speed_o,
        output speed_ack_o,
        output tick_o,
        output refclk_o,
        output phy_rst_n_o,
        output phy_ready_o
    );

    modport master (
        output speed_i,
        output phy_reset_req_i,
        input  speed_o,
        input  speed_ack_o,
        input  tick_o,
        input  refclk_o,
        input  phy_rst_n_o,
        input  phy_ready_o
    );
endinterface

// File: rtl/ethernet_timebase.sv
// Ethernet timebase: RMII reference clock divider, 10/100 shift tick with
// glitch-free speed switching, and PHY hard-reset sequencer.
module ethernet_timebase #(
    parameter int unsigned SYS_CLOCK_FREQ = 100_000_000,
    parameter int unsigned REFCLK_FREQ    = 50_000_000,
    parameter int unsigned PHY_RESET_US   = 10,
    parameter int unsigned PHY_SETTLE_US  = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    ethernet_timebase_if.slave bus
);
    localparam int unsigned Div       = SYS_CLOCK_FREQ / REFCLK_FREQ;
    localparam int unsigned CycPerUs  = SYS_CLOCK_FREQ / 1_000_000;
    localparam int unsigned HoldCyc   = CycPerUs * PHY_RESET_US;
    localparam int unsigned SettleCyc = CycPerUs * PHY_SETTLE_US;
    localparam int unsigned DlyMax    = (HoldCyc > SettleCyc) ? HoldCyc : SettleCyc;
    localparam int unsigned RefW      = (Div > 2) ? $clog2(Div) : 1;
    localparam int unsigned DlyW      = (DlyMax > 2) ? $clog2(DlyMax) : 1;

    localparam logic [RefW-1:0] RefLast    = RefW'(Div - 1);
    localparam logic [RefW-1:0] RefHalf    = RefW'(Div / 2);
    localparam logic [DlyW-1:0] HoldLast   = DlyW'(HoldCyc - 1);
    localparam logic [DlyW-1:0] SettleLast = DlyW'(SettleCyc - 1);

    if (Div < 2 || (Div % 2) != 0 || Div * REFCLK_FREQ != SYS_CLOCK_FREQ) begin : g_bad_div
        $error("ethernet_timebase: SYS_CLOCK_FREQ/REFCLK_FREQ must be an even integer >= 2");
    end
    if (HoldCyc == 0 || SettleCyc == 0) begin : g_bad_delay
        $error("ethernet_timebase: PHY hold and settle times must be at least one cycle");
    end

    typedef enum logic [1:0] {StHold, StSettle, StReady} state_e;

    state_e          state_q;
    logic [DlyW-1:0] dly_q;
    logic [RefW-1:0] ref_cnt_q;
    logic [RefW-1:0] ref_cnt_d;
    logic [3:0]      dec_cnt_q;
    logic            period_end;
    logic            decade_end;
    logic            refclk_q;
    logic            speed_q;
    logic            speed_ack_q;
    logic            tick_q;
    logic            phy_rst_n_q;
    logic            phy_ready_q;

    // Period / decade boundary decode and next divider count.
    always_comb begin
        period_end = (ref_cnt_q == RefLast);
        decade_end = period_end && (dec_cnt_q == 4'd9);
        ref_cnt_d  = period_end ? '0 : ref_cnt_q + RefW'(1);
    end

    // Free-running divider; runs in every FSM state so the PHY sees refclk in reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ref_cnt_q <= '0;
            dec_cnt_q <= '0;
            refclk_q  <= 1'b0;
        end else begin
            ref_cnt_q <= ref_cnt_d;
            // Decoded from the next count so refclk_o is aligned with ref_cnt.
            refclk_q  <= (ref_cnt_d >= RefHalf);
            if (period_end) begin
                dec_cnt_q <= (dec_cnt_q == 4'd9) ? 4'd0 : dec_cnt_q + 4'd1;
            end
        end
    end

    // Speed is only switched on a decade boundary, so no tick interval is ever cut short.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            speed_q     <= 1'b1;
            speed_ack_q <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            speed_ack_q <= decade_end && (bus.speed_i != speed_q);
            if (decade_end) begin
                speed_q <= bus.speed_i;
            end
            // Old speed decides this boundary's tick; a pending reset request suppresses it.
            tick_q <= (state_q == StReady) && !bus.phy_reset_req_i &&
                      (speed_q ? period_end : decade_end);
        end
    end

    // PHY reset sequencer; outputs are set together with the state they belong to.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StHold;
            dly_q       <= '0;
            phy_rst_n_q <= 1'b0;
            phy_ready_q <= 1'b0;
        end else if (bus.phy_reset_req_i) begin
            state_q     <= StHold;
            dly_q       <= '0;
            phy_rst_n_q <= 1'b0;
            phy_ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                StHold: begin
                    if (dly_q == HoldLast) begin
                        state_q     <= StSettle;
                        dly_q       <= '0;
                        phy_rst_n_q <= 1'b1;
                    end else begin
                        dly_q <= dly_q + DlyW'(1);
                    end
                end
                StSettle: begin
                    if (dly_q == SettleLast) begin
                        state_q     <= StReady;
                        dly_q       <= '0;
                        phy_ready_q <= 1'b1;
                    end else begin
                        dly_q <= dly_q + DlyW'(1);
                    end
                end
                StReady: begin
                    dly_q <= '0;
                end
                default: begin
                    state_q     <= StHold;
                    dly_q       <= '0;
                    phy_rst_n_q <= 1'b0;
                    phy_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.refclk_o    = refclk_q;
    assign bus.speed_o     = speed_q;
    assign bus.speed_ack_o = speed_ack_q;
    assign bus.tick_o      = tick_q;
    assign bus.phy_rst_n_o = phy_rst_n_q;
    assign bus.phy_ready_o = phy_ready_q;
endmodule

// File: tb/tb_ethernet_timebase.sv
// Bench for ethernet_timebase: a 100 MHz (DIV=2) and a 200 MHz (DIV=4) instance
// share stimulus; a cycle-count reference model feeds a scoreboard queue.
module tb_ethernet_timebase;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic speed = 1'b1;
    logic req = 1'b0;

    always #5 clk = ~clk;

    ethernet_timebase_if if_a ();
    ethernet_timebase_if if_b ();

    assign if_a.speed_i         = speed;
    assign if_a.phy_reset_req_i = req;
    assign if_b.speed_i         = speed;
    assign if_b.phy_reset_req_i = req;

    ethernet_timebase #(
        .SYS_CLOCK_FREQ(100_000_000),
        .REFCLK_FREQ   (50_000_000),
        .PHY_RESET_US  (10),
        .PHY_SETTLE_US (5)
    ) dut_a (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (if_a)
    );

    ethernet_timebase #(
        .SYS_CLOCK_FREQ(200_000_000),
        .REFCLK_FREQ   (50_000_000),
        .PHY_RESET_US  (10),
        .PHY_SETTLE_US (5)
    ) dut_b (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (if_b)
    );

    // Model state: cycles since reset release, cycle at which the current hold began,
    // and the applied speed.
    int cyc   [2];
    int start [2];
    bit spd   [2];

    logic [11:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int ncyc  = 0;

    // Expected outputs after one clock edge: {speed, ack, tick, refclk, phy_rst_n, ready}.
    function automatic logic [5:0] model_step(input int i, input bit r, input bit s,
                                              input bit q);
        int d;
        int h;
        int st;
        int c;
        bit pe;
        bit db;
        bit rdy;
        bit tk;
        bit ak;
        d  = (i == 0) ? 2 : 4;
        h  = (i == 0) ? 1000 : 2000;
        st = h / 2;
        tk = 1'b0;
        ak = 1'b0;
        if (r) begin
            cyc[i]   = 0;
            start[i] = 0;
            spd[i]   = 1'b1;
        end else begin
            c   = cyc[i];
            pe  = (c % d) == d - 1;
            db  = (c % (10 * d)) == 10 * d - 1;
            rdy = (c - start[i]) >= h + st;
            tk  = rdy && !q && (spd[i] ? pe : db);
            ak  = db && (s != spd[i]);
            if (db) spd[i] = s;
            cyc[i] = c + 1;
            if (q) start[i] = cyc[i];
        end
        return {spd[i], ak, tk, (cyc[i] % d) >= d / 2, (cyc[i] - start[i]) >= h,
                (cyc[i] - start[i]) >= h + st};
    endfunction

    // Drive one cycle of inputs and queue the response expected after the next edge.
    task automatic step(input bit r, input bit s, input bit q);
        logic [5:0] ea;
        logic [5:0] eb;
        @(negedge clk);
        rst   = r;
        speed = s;
        req   = q;
        ea = model_step(0, r, s, q);
        eb = model_step(1, r, s, q);
        exp_q.push_back({eb, ea});
    endtask

    task automatic run(input int n, input bit s);
        for (int k = 0; k < n; k++) step(1'b0, s, 1'b0);
    endtask

    // Monitor: compare every presented output set against the queued expectation.
    initial begin
        logic [11:0] e;
        logic [5:0]  ga;
        logic [5:0]  gb;
        forever begin
            @(posedge clk);
            #1;
            ncyc++;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                ga = {if_a.speed_o, if_a.speed_ack_o, if_a.tick_o, if_a.refclk_o,
                      if_a.phy_rst_n_o, if_a.phy_ready_o};
                gb = {if_b.speed_o, if_b.speed_ack_o, if_b.tick_o, if_b.refclk_o,
                      if_b.phy_rst_n_o, if_b.phy_ready_o};
                total++;
                if (ga !== e[5:0]) begin
                    bad++;
                    $display("FAIL dut100 cyc=%0d got=%b want=%b (spd,ack,tick,ref,rstn,rdy)",
                             ncyc, ga, e[5:0]);
                end
                total++;
                if (gb !== e[11:6]) begin
                    bad++;
                    $display("FAIL dut200 cyc=%0d got=%b want=%b (spd,ack,tick,ref,rstn,rdy)",
                             ncyc, gb, e[11:6]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit sv;
        int w;
        for (int i = 0; i < 2; i++) begin
            cyc[i]   = 0;
            start[i] = 0;
            spd[i]   = 1'b1;
        end

        // Reset, then full bring-up of both instances at 100 Mb/s.
        repeat (4) step(1'b1, 1'b1, 1'b0);
        run(3200, 1'b1);

        // Random speed changes and short glitches while ready.
        sv = 1'b1;
        for (int k = 0; k < 40; k++) begin
            w = $urandom_range(1, 70);
            sv = ~sv;
            if ($urandom_range(0, 2) == 0) begin
                run($urandom_range(1, 8), sv);
                sv = ~sv;
            end
            run(w, sv);
        end
        sv = 1'b0;
        run(100, sv);

        // Reset request in READY, again at hold cycle 999, then during SETTLE.
        step(1'b0, sv, 1'b1);
        run(999, sv);
        step(1'b0, sv, 1'b1);
        run(1200, sv);
        step(1'b0, sv, 1'b1);
        run(3100, sv);

        // 10 Mb/s selected before the PHY becomes ready.
        repeat (3) step(1'b1, 1'b0, 1'b0);
        run(3200, 1'b0);

        // rst_i asserted while the 200 MHz instance is settling.
        repeat (3) step(1'b1, 1'b1, 1'b0);
        run(2500, 1'b1);
        repeat (2) step(1'b1, 1'b1, 1'b0);
        run(300, 1'b1);

        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
